tcl_ingress: RTL

Ingress stage directly upstream of the transaction-layer core. It accepts a 12-bit word stream over a valid/ready handshake, buffers it in a 2-entry skid buffer, and drives the core's `pushIn`/`dataInputFIFO` pair under credit-based flow control. It also sequences core bring-up: it latches the threshold configuration, drives the core's `init` pulse and `Umbral_bajo`/`Umbral_alto`, and only forwards traffic once the core is configured.

---
 rtl/tcl_ingress_pkg.sv | 24 ++
 rtl/skid_buf2.sv | 65 ++++++
 rtl/tcl_ingress.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/tcl_ingress_pkg.sv
// Shared types and widths for the transaction-layer ingress stage.
package tcl_ingress_pkg;

    localparam int unsigned WORD_W    = 12;
    localparam int unsigned DEST_HI   = 11;
    localparam int unsigned DEST_LO   = 10;
    localparam int unsigned DEST_W    = DEST_HI - DEST_LO + 1;
    localparam int unsigned PAYLOAD_W = DEST_LO;
    localparam int unsigned THR_W     = 3;
    localparam int unsigned CRED_W    = 4;
    localparam int unsigned ICNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] payload;
    } tcl_word_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO with flush; slot0 is always the head word.
module skid_buf2
    import tcl_ingress_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  tcl_word_t push_data,
    input  logic      pop,
    input  logic      flush,
    output logic [1:0] count,
    output tcl_word_t head
);

    tcl_word_t  slot0_q, slot0_d;
    tcl_word_t  slot1_q, slot1_d;
    logic [1:0] count_q, count_d;

    // Caller guarantees no push when full and no pop when empty.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) slot0_d = push_data;
                    else                 slot1_d = push_data;
                    count_d = 2'(count_q + 2'd1);
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = 2'(count_q - 2'd1);
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        slot0_d = push_data;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = push_data;
                    end
                end
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = slot0_q;

endmodule

// File: rtl/tcl_ingress.sv
// Ingress stage: core bring-up sequencing plus credit-gated forwarding via a 2-deep skid.
// Optional push statistics counter enabled by TCL_INGRESS_STATS_EN.
module tcl_ingress
    import tcl_ingress_pkg::*;
#(
    parameter int unsigned CREDITS     = 8,
    parameter int unsigned INIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [THR_W-1:0]  cfg_umbral_bajo,
    input  logic [THR_W-1:0]  cfg_umbral_alto,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              credit_return,
    output logic              init,
    output logic [THR_W-1:0]  Umbral_bajo,
    output logic [THR_W-1:0]  Umbral_alto,
    output logic              pushIn,
    output logic [WORD_W-1:0] dataInputFIFO,
    output logic              busy,
    output logic [CRED_W-1:0] credits
`ifdef TCL_INGRESS_STATS_EN
    ,
    output logic [7:0]        push_count
`endif
);

    state_e            state_q, state_d;
    logic [ICNT_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_q, init_d;
    logic [THR_W-1:0]  bajo_q, bajo_d, alto_q, alto_d;
    logic              push_in_q, push_in_d;
    tcl_word_t         data_q, data_d;
    logic              busy_q, busy_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic              in_ready_q, in_ready_d;

    logic       sb_push, sb_pop, sb_flush;
    logic [1:0] sb_count, sb_cnt_nxt;
    tcl_word_t  sb_head;

    skid_buf2 u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (sb_push),
        .push_data (tcl_word_t'(in_data)),
        .pop       (sb_pop),
        .flush     (sb_flush),
        .count     (sb_count),
        .head      (sb_head)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        init_d     = 1'b0;
        bajo_d     = bajo_q;
        alto_d     = alto_q;
        push_in_d  = 1'b0;
        data_d     = data_q;
        credits_d  = credits_q;
        sb_push    = 1'b0;
        sb_pop     = 1'b0;
        sb_flush   = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_INIT: begin
                if (init_cnt_q != '0) begin
                    init_d     = 1'b1;
                    init_cnt_d = init_cnt_q - ICNT_W'(1);
                end else begin
                    state_d   = ST_RUN;
                    credits_d = CRED_W'(CREDITS);
                end
            end
            ST_RUN: begin
                sb_push = in_valid && in_ready_q;
                sb_pop  = (sb_count != 2'd0) && (credits_q != '0);
                if (sb_pop) begin
                    push_in_d = 1'b1;
                    data_d    = sb_head;
                end
                // Push and return in the same cycle cancel out.
                if (sb_pop && !credit_return) begin
                    credits_d = credits_q - CRED_W'(1);
                end else if (!sb_pop && credit_return && (credits_q < CRED_W'(CREDITS))) begin
                    credits_d = credits_q + CRED_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A configuration strobe restarts bring-up from any state and drops held traffic.
        if (cfg_start) begin
            state_d    = ST_INIT;
            init_cnt_d = ICNT_W'(INIT_CYCLES);
            init_d     = 1'b0;
            bajo_d     = cfg_umbral_bajo;
            alto_d     = cfg_umbral_alto;
            push_in_d  = 1'b0;
            data_d     = data_q;
            credits_d  = credits_q;
            sb_push    = 1'b0;
            sb_pop     = 1'b0;
            sb_flush   = 1'b1;
        end
    end

    always_comb begin
        sb_cnt_nxt = sb_flush ? 2'd0 : 2'(sb_count + {1'b0, sb_push} - {1'b0, sb_pop});
        in_ready_d = (state_d == ST_RUN) && (sb_cnt_nxt < 2'd2);
        busy_d     = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= '0;
            init_q     <= 1'b0;
            bajo_q     <= '0;
            alto_q     <= '0;
            push_in_q  <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b1;
            credits_q  <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            init_q     <= init_d;
            bajo_q     <= bajo_d;
            alto_q     <= alto_d;
            push_in_q  <= push_in_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            credits_q  <= credits_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign init          = init_q;
    assign Umbral_bajo   = bajo_q;
    assign Umbral_alto   = alto_q;
    assign pushIn        = push_in_q;
    assign dataInputFIFO = data_q;
    assign busy          = busy_q;
    assign credits       = credits_q;

`ifdef TCL_INGRESS_STATS_EN
    localparam int unsigned STAT_W = 8;
    logic [STAT_W-1:0] push_count_q, push_count_d;

    // Counts pushIn pulses; restarts on every bring-up.
    always_comb begin
        push_count_d = push_count_q;
        if (cfg_start)      push_count_d = '0;
        else if (push_in_d) push_count_d = push_count_q + STAT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) push_count_q <= '0;
        else        push_count_q <= push_count_d;
    end

    assign push_count = push_count_q;
`else
    // Statistics counter not built.
`endif

endmodule
